// File: rtl/freq_count_bank_if.sv
// freq_count_bank_if -- control/result bundle for freq_count_bank.
//   enable     : high = measure, low = idle/flush
//   gate_len   : internal window length in aclk cycles (0 acts as 1)
//   gate_i     : external gate level (used only by EXT_GATE=1 builds)
//   event_i    : per-channel event levels, channel n = bit n
//   freq_o     : latched per-window rising-edge counts, channel n = [n*CNT_WIDTH +: CNT_WIDTH]
//   ovf_o      : per-channel saturation flag for the latched window
//   done_o     : one-cycle pulse when freq_o/ovf_o update
//   windows_o  : completed-window counter, wraps
// master = stimulus side, slave = the counter bank.
interface freq_count_bank_if #(
   parameter int NCHAN      = 4,
   parameter int CNT_WIDTH  = 32,
   parameter int GATE_WIDTH = 32
);
   logic                       enable;
   logic [GATE_WIDTH-1:0]      gate_len;
   logic                       gate_i;
   logic [NCHAN-1:0]           event_i;
   logic [NCHAN*CNT_WIDTH-1:0] freq_o;
   logic [NCHAN-1:0]           ovf_o;
   logic                       done_o;
   logic [15:0]                windows_o;

   modport master (output enable, gate_len, gate_i, event_i,
                   input  freq_o, ovf_o, done_o, windows_o);
   modport slave  (input  enable, gate_len, gate_i, event_i,
                   output freq_o, ovf_o, done_o, windows_o);
endinterface

// File: rtl/freq_count_bank.sv
// freq_count_bank -- NCHAN independent rising-edge counters sharing one
// measurement window. The window comes either from an internal gate timer
// (EXT_GATE=0, length gate_len) or from rising edges of gate_i (EXT_GATE=1).
// Each closing window latches per-channel counts and saturation flags.
//   aclk  : sole clock, rising edge
//   reset : synchronous, active high
//   bus   : freq_count_bank_if slave modport (see interface header)

// Per-channel counter: live count, sticky in-window overflow and the
// latched result of the last closed window.
module freq_count_lane #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 aclk,
   input  logic                 reset,
   input  logic                 enable_i,
   input  logic                 gate_end_i,
   input  logic                 evt_edge_i,
   output logic [CNT_WIDTH-1:0] freq_o,
   output logic                 ovf_o
);
   localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, freq_q, freq_d;
   logic                 wovf_q, wovf_d, ovf_q, ovf_d;
   logic                 sat;

   assign sat = &cnt_q;

   always_comb begin
      cnt_d  = cnt_q;
      wovf_d = wovf_q;
      freq_d = freq_q;
      ovf_d  = ovf_q;
      if (!enable_i) begin
         cnt_d  = '0;
         wovf_d = 1'b0;
      end else if (gate_end_i) begin
         // an edge in the closing cycle still belongs to the closing window
         freq_d = (sat || !evt_edge_i) ? cnt_q : cnt_q + C_ONE;
         ovf_d  = wovf_q | (sat & evt_edge_i);
         cnt_d  = '0;
         wovf_d = 1'b0;
      end else if (evt_edge_i) begin
         if (sat) wovf_d = 1'b1;
         else     cnt_d  = cnt_q + C_ONE;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         cnt_q  <= '0;
         wovf_q <= 1'b0;
         freq_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wovf_q <= wovf_d;
         freq_q <= freq_d;
         ovf_q  <= ovf_d;
      end
   end

   assign freq_o = freq_q;
   assign ovf_o  = ovf_q;
endmodule

module freq_count_bank #(
   parameter int NCHAN      = 4,
   parameter int CNT_WIDTH  = 32,
   parameter int GATE_WIDTH = 32,
   parameter bit EXT_GATE   = 1'b0
) (
   input  logic            aclk,
   input  logic            reset,
   freq_count_bank_if.slave bus
);
   logic [NCHAN-1:0]                evt_q;
   logic [NCHAN-1:0]                evt_edge;
   logic                            gate_end;
   logic                            done_q;
   logic [15:0]                     win_q;
   logic [NCHAN-1:0][CNT_WIDTH-1:0] freq_w;
   logic [NCHAN-1:0]                ovf_w;

   // Edge history is deliberately not reset: a level held high across
   // reset release must not look like a fresh edge.
   always_ff @(posedge aclk) evt_q <= bus.event_i;
   assign evt_edge = bus.event_i & ~evt_q;

   if (EXT_GATE == 1'b0) begin : g_int_gate
      localparam logic [GATE_WIDTH-1:0] G_ONE = GATE_WIDTH'(1);
      logic [GATE_WIDTH-1:0] tmr_q, tmr_d, len_q, len_d;

      // Window length is captured while the timer sits at 0, so a gate_len
      // write mid-window only affects the next window.
      always_comb begin
         len_d    = len_q;
         if (tmr_q == '0) len_d = (bus.gate_len == '0) ? G_ONE : bus.gate_len;
         gate_end = bus.enable && (tmr_q == len_d - G_ONE);
         tmr_d    = (!bus.enable || gate_end) ? '0 : tmr_q + G_ONE;
      end

      always_ff @(posedge aclk) begin
         if (reset) begin
            tmr_q <= '0;
            len_q <= '0;
         end else begin
            tmr_q <= tmr_d;
            len_q <= len_d;
         end
      end
   end else begin : g_ext_gate
      logic gate_q;
      always_ff @(posedge aclk) gate_q <= bus.gate_i;
      assign gate_end = bus.enable & bus.gate_i & ~gate_q;
   end

   for (genvar n = 0; n < NCHAN; n++) begin : g_lane
      freq_count_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
         .aclk       (aclk),
         .reset      (reset),
         .enable_i   (bus.enable),
         .gate_end_i (gate_end),
         .evt_edge_i (evt_edge[n]),
         .freq_o     (freq_w[n]),
         .ovf_o      (ovf_w[n])
      );
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         done_q <= 1'b0;
         win_q  <= '0;
      end else begin
         done_q <= gate_end;
         win_q  <= win_q + {15'd0, gate_end};
      end
   end

   assign bus.freq_o    = freq_w;
   assign bus.ovf_o     = ovf_w;
   assign bus.done_o    = done_q;
   assign bus.windows_o = win_q;
endmodule

// File: tb/tb_freq_count_bank.sv
// Directed bench for freq_count_bank: three builds (4ch/32b internal gate,
// 2ch/4b internal gate for saturation, 1ch/8b external gate).
module tb_freq_count_bank;
   logic aclk = 1'b0;
   logic reset;
   always #5 aclk = ~aclk;

   freq_count_bank_if #(.NCHAN(4), .CNT_WIDTH(32), .GATE_WIDTH(32)) ia ();
   freq_count_bank_if #(.NCHAN(2), .CNT_WIDTH(4),  .GATE_WIDTH(32)) ib ();
   freq_count_bank_if #(.NCHAN(1), .CNT_WIDTH(8),  .GATE_WIDTH(8))  ic ();

   freq_count_bank #(.NCHAN(4), .CNT_WIDTH(32), .GATE_WIDTH(32), .EXT_GATE(1'b0))
      u_dut_a (.aclk(aclk), .reset(reset), .bus(ia));
   freq_count_bank #(.NCHAN(2), .CNT_WIDTH(4), .GATE_WIDTH(32), .EXT_GATE(1'b0))
      u_dut_b (.aclk(aclk), .reset(reset), .bus(ib));
   freq_count_bank #(.NCHAN(1), .CNT_WIDTH(8), .GATE_WIDTH(8), .EXT_GATE(1'b1))
      u_dut_c (.aclk(aclk), .reset(reset), .bus(ic));

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;
   int          gcnt  = 1;
   logic        pat_a, b_fast;
   logic        g_prev, g_cur;
   int          n, w0, nwin;
   logic [127:0] fsave;
   logic        exp_done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Periodic patterns are derived from the free-running step counter so
   // every window of a multiple of the period sees an exact edge count.
   task automatic drive();
      if (pat_a) ia.event_i = {1'b1, 1'b0, cyc[1], cyc[0]};
      ib.event_i = {cyc[2], (b_fast ? cyc[0] : cyc[2])};
      ic.event_i = cyc[0];
      ic.gate_i  = (gcnt == 0);
      gcnt       = (gcnt == 36) ? 0 : gcnt + 1;
   endtask

   task automatic step();
      g_prev = g_cur;
      g_cur  = ic.gate_i;
      @(posedge aclk);
      #1;
      cyc++;
      drive();
   endtask

   function automatic logic done_of(input int w);
      case (w)
         0:       return ia.done_o;
         1:       return ib.done_o;
         default: return ic.done_o;
      endcase
   endfunction

   task automatic wait_done(input int w, input int maxc, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!done_of(w) && cnt < maxc);
   endtask

   initial begin
      reset = 1'b1;
      pat_a = 1'b1; b_fast = 1'b1; g_prev = 1'b0; g_cur = 1'b0;
      ia.enable = 1'b0; ia.gate_len = 32'd100; ia.gate_i = 1'b0; ia.event_i = '0;
      ib.enable = 1'b0; ib.gate_len = 32'd64;  ib.gate_i = 1'b0; ib.event_i = '0;
      ic.enable = 1'b0; ic.gate_len = 8'd0;    ic.gate_i = 1'b0; ic.event_i = '0;
      repeat (3) step();
      chk("rst_a_freq", {63'd0, ia.freq_o == '0}, 64'd1);
      chk("rst_a_ovf",  ia.ovf_o, 0);
      chk("rst_a_done", ia.done_o, 0);
      chk("rst_a_win",  ia.windows_o, 0);
      chk("rst_b_freq", ib.freq_o, 0);
      chk("rst_c_win",  ic.windows_o, 0);

      // basic counting, window 100
      reset = 1'b0;
      ia.enable = 1'b1;
      wait_done(0, 200, n);
      chk("a_win1_len", n, 100);
      chk("a_ch0", ia.freq_o[0 +: 32], 50);
      chk("a_ch1", ia.freq_o[32 +: 32], 25);
      chk("a_ch2", ia.freq_o[64 +: 32], 0);
      chk("a_ch3_held_hi", ia.freq_o[96 +: 32], 0);
      chk("a_ovf", ia.ovf_o, 0);
      chk("a_win_cnt1", ia.windows_o, 1);
      wait_done(0, 200, n);
      chk("a_win2_len", n, 100);
      chk("a_win2_ch0", ia.freq_o[0 +: 32], 50);
      chk("a_win_cnt2", ia.windows_o, 2);
      step();
      chk("a_done_1cyc", ia.done_o, 0);

      // gate_len change mid-window applies to the next window only
      ia.gate_len = 32'd10;
      wait_done(0, 200, n);
      chk("a_len_keep100", n, 99);
      wait_done(0, 200, n);
      chk("a_len10", n, 10);
      repeat (5) step();
      ia.gate_len = 32'd20;
      wait_done(0, 200, n);
      chk("a_len10_mid", n, 5);
      wait_done(0, 200, n);
      chk("a_len20", n, 20);
      chk("a_len20_ch0", ia.freq_o[0 +: 32], 10);
      chk("a_len20_ch1", ia.freq_o[32 +: 32], 5);

      // enable low for 3 cycles mid-window
      repeat (5) step();
      ia.enable = 1'b0;
      fsave = ia.freq_o;
      w0 = ia.windows_o;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("a_dis_done", ia.done_o, 0);
         chk("a_dis_win", ia.windows_o, w0);
         chk("a_dis_freq", {63'd0, ia.freq_o == fsave}, 64'd1);
      end
      ia.enable = 1'b1;
      wait_done(0, 200, n);
      chk("a_reen_len", n, 20);
      chk("a_reen_ch0", ia.freq_o[0 +: 32], 10);
      chk("a_reen_win", ia.windows_o, w0 + 1);

      // edge only in the gate_end cycle
      ia.gate_len = 32'd10;
      pat_a = 1'b0;
      ia.event_i = 4'h0;
      wait_done(0, 200, n);
      chk("a_quiet_len", n, 10);
      chk("a_quiet_freq", {63'd0, ia.freq_o == '0}, 64'd1);
      repeat (9) step();
      ia.event_i = 4'h1;
      step();
      chk("a_gend_done", ia.done_o, 1);
      chk("a_gend_cnt", ia.freq_o[0 +: 32], 1);
      wait_done(0, 200, n);
      chk("a_next_len", n, 10);
      chk("a_next_cnt", ia.freq_o[0 +: 32], 0);

      // gate_len = 0 behaves as a 1-cycle window
      ia.gate_len = 32'd0;
      w0 = ia.windows_o;
      for (int k = 0; k < 4; k++) begin
         ia.event_i = {3'b000, k[0]};
         step();
         chk("a_l0_done", ia.done_o, 1);
         chk("a_l0_ch0", ia.freq_o[0 +: 32], k[0]);
      end
      chk("a_l0_win", ia.windows_o, w0 + 4);

      // reset mid-window with events held high across release
      ia.gate_len = 32'd100;
      ia.event_i = 4'hF;
      repeat (50) step();
      chk("a_mid_done", ia.done_o, 0);
      reset = 1'b1;
      repeat (2) step();
      chk("a_rst_freq", {63'd0, ia.freq_o == '0}, 64'd1);
      chk("a_rst_ovf", ia.ovf_o, 0);
      chk("a_rst_done", ia.done_o, 0);
      chk("a_rst_win", ia.windows_o, 0);
      reset = 1'b0;
      wait_done(0, 200, n);
      chk("a_post_len", n, 100);
      chk("a_post_freq", {63'd0, ia.freq_o == '0}, 64'd1);
      chk("a_post_win", ia.windows_o, 1);
      ia.enable = 1'b0;

      // saturation on a 4-bit counter
      ib.enable = 1'b1;
      wait_done(1, 200, n);
      chk("b_len", n, 64);
      chk("b_ch0_sat", ib.freq_o[3:0], 15);
      chk("b_ovf0", ib.ovf_o[0], 1);
      chk("b_ch1", ib.freq_o[7:4], 8);
      chk("b_ovf1", ib.ovf_o[1], 0);
      b_fast = 1'b0;
      wait_done(1, 200, n);
      chk("b_ovf0_clr", ib.ovf_o[0], 0);
      wait_done(1, 200, n);
      chk("b_slow_ch0", ib.freq_o[3:0], 8);
      chk("b_slow_ovf", ib.ovf_o, 0);
      ib.enable = 1'b0;

      // external gate, pulse every 37 cycles
      ic.enable = 1'b1;
      nwin = 0;
      for (int k = 0; k < 185; k++) begin
         step();
         exp_done = g_cur & ~g_prev;
         chk("c_done", ic.done_o, exp_done);
         if (ic.done_o) begin
            nwin++;
            if (nwin > 1)
               chk("c_freq_18_19", {63'd0, (ic.freq_o == 8'd18) || (ic.freq_o == 8'd19)}, 64'd1);
         end
      end
      chk("c_win", ic.windows_o, nwin);
      chk("c_win_min", {63'd0, nwin >= 4}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
